dma_priority_arbiter: RTL and testbench

- Request/priority stage directly upstream of the DMA timing-and-control state machine.
- Conditions the four DREQ lines with mask, software-request and sense bits, and resolves fixed or rotating priority.
- Runs the HRQ/HLDA hold handshake with the CPU, then drives DACK and hands the winning channel to timing-and-control.
- Releases the bus when timing-and-control reports end of service.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_priority_encoder.sv | 30 +++
 rtl/dma_priority_arbiter.sv | 130 +++++++++++++
 tb/tb_dma_priority_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants and types for the DMA request/priority stage.
// Channel count, channel index type and the arbiter state encoding.
package dma_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_REQ,
        SERVICE
    } arbState_t;

    typedef logic [CH_W-1:0] chIdx_t;

endpackage

// File: rtl/dma_priority_encoder.sv
// Rotating-start priority encoder: the first requesting channel at or after
// top_pri_i, wrapping modulo NUM_CH, wins.
module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] eff_req_i,
    input  chIdx_t            top_pri_i,
    output chIdx_t            winner_o,
    output logic              any_req_o
);

    chIdx_t idx;
    logic   found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = chIdx_t'((32'(top_pri_i) + i) % NUM_CH);
            if (!found && eff_req_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end

    assign any_req_o = |eff_req_i;

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA request conditioning, fixed/rotating priority resolution and HRQ/HLDA
// hold handshake; hands one granted channel at a time to timing-and-control.
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              priorityType,
    input  logic              dreqSenseLow,
    input  logic              controllerDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] swReqReg,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output chIdx_t            activeChannel,
    output logic              channelValid,
    output logic              serviceStart
);

    // Registered copies of the request-side inputs
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] sw_req_q;
    logic              pri_type_q;
    logic              sense_low_q;
    logic              disable_q;

    arbState_t         state_q, state_d;
    chIdx_t            top_pri_q, top_pri_d;
    chIdx_t            active_q, active_d;
    logic              hrq_q, valid_q, start_q;
    logic [NUM_CH-1:0] dack_q, dack_d;

    logic [NUM_CH-1:0] eff_req;
    chIdx_t            winner;
    logic              any_req;

    assign eff_req = disable_q ? '0
                   : (((dreq_q ^ {NUM_CH{sense_low_q}}) & ~mask_q) | sw_req_q);

    dma_priority_encoder u_encoder (
        .eff_req_i (eff_req),
        .top_pri_i (top_pri_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        top_pri_d = pri_type_q ? top_pri_q : '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = HOLD_REQ;
                end
            end
            HOLD_REQ: begin
                if (!any_req) begin
                    state_d = IDLE;
                end else if (HLDA) begin
                    state_d  = SERVICE;
                    active_d = winner;
                end
            end
            SERVICE: begin
                // serviceDone wins over a simultaneous HLDA drop
                if (serviceDone) begin
                    state_d = IDLE;
                    if (pri_type_q) begin
                        top_pri_d = (active_q == chIdx_t'(NUM_CH - 1)) ? '0
                                  : active_q + chIdx_t'(1);
                    end
                end else if (!HLDA) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dack_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            dack_d[i] = (state_d == SERVICE) && (active_d == chIdx_t'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dreq_q      <= '0;
            mask_q      <= '0;
            sw_req_q    <= '0;
            pri_type_q  <= 1'b0;
            sense_low_q <= 1'b0;
            disable_q   <= 1'b0;
            state_q     <= IDLE;
            top_pri_q   <= '0;
            active_q    <= '0;
            hrq_q       <= 1'b0;
            dack_q      <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            dreq_q      <= DREQ;
            mask_q      <= maskReg;
            sw_req_q    <= swReqReg;
            pri_type_q  <= priorityType;
            sense_low_q <= dreqSenseLow;
            disable_q   <= controllerDisable;
            state_q     <= state_d;
            top_pri_q   <= top_pri_d;
            active_q    <= active_d;
            hrq_q       <= (state_d != IDLE);
            dack_q      <= dack_d;
            valid_q     <= (state_d == SERVICE);
            start_q     <= (state_d == SERVICE) && (state_q != SERVICE);
        end
    end

    assign HRQ           = hrq_q;
    assign DACK          = dack_q;
    assign activeChannel = active_q;
    assign channelValid  = valid_q;
    assign serviceStart  = start_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus
// randomized transactions checked against a request/priority reference model.
module tb_dma_priority_arbiter;
    import dma_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic              priorityType;
    logic              dreqSenseLow;
    logic              controllerDisable;
    logic [NUM_CH-1:0] maskReg;
    logic [NUM_CH-1:0] swReqReg;
    logic              serviceDone;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    chIdx_t            activeChannel;
    logic              channelValid;
    logic              serviceStart;

    int errors = 0;
    int checks = 0;
    int top_model = 0;

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .DREQ              (DREQ),
        .HLDA              (HLDA),
        .priorityType      (priorityType),
        .dreqSenseLow      (dreqSenseLow),
        .controllerDisable (controllerDisable),
        .maskReg           (maskReg),
        .swReqReg          (swReqReg),
        .serviceDone       (serviceDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .activeChannel     (activeChannel),
        .channelValid      (channelValid),
        .serviceStart      (serviceStart)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [NUM_CH-1:0] model_eff(input logic [NUM_CH-1:0] dreq,
                                                    input logic sense, input logic dis,
                                                    input logic [NUM_CH-1:0] mask,
                                                    input logic [NUM_CH-1:0] sw);
        logic [NUM_CH-1:0] r;
        r = '0;
        if (!dis) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r[i] = (((dreq[i] != sense)) && !mask[i]) || sw[i];
            end
        end
        return r;
    endfunction

    function automatic int model_winner(input logic [NUM_CH-1:0] eff, input int top);
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff[(top + k) % NUM_CH]) return (top + k) % NUM_CH;
        end
        return -1;
    endfunction

    // End the current service and return the inputs to a no-request state
    task automatic release_service();
        serviceDone = 1'b1;
        DREQ        = {NUM_CH{dreqSenseLow}};
        swReqReg    = '0;
        tick();
        serviceDone = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        checks++;
        if ({HRQ, DACK, activeChannel, channelValid, serviceStart} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b want all zero",
                     {HRQ, DACK, activeChannel, channelValid, serviceStart});
        end
    endtask

    task automatic test_fixed_latency();
        priorityType = 1'b0;
        HLDA         = 1'b1;
        DREQ         = 4'b0011;
        tick();
        checks++;
        if (HRQ !== 1'b0) begin
            errors++; $display("FAIL fixed_edge_n: HRQ got %b want 0", HRQ);
        end
        tick();
        checks++;
        if ({HRQ, DACK, channelValid, serviceStart} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fixed_edge_n1: got %b want 1000000",
                     {HRQ, DACK, channelValid, serviceStart});
        end
        tick();
        checks++;
        if ({HRQ, DACK, activeChannel, channelValid, serviceStart}
            !== {1'b1, 4'b0001, chIdx_t'(0), 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL fixed_edge_n2: got %b want 100010011",
                     {HRQ, DACK, activeChannel, channelValid, serviceStart});
        end
        tick();
        checks++;
        if ({DACK, serviceStart} !== {4'b0001, 1'b0}) begin
            errors++; $display("FAIL fixed_edge_n3: got %b want 00010", {DACK, serviceStart});
        end
        release_service();
        top_model = 0;
    endtask

    task automatic test_rotating();
        logic [NUM_CH-1:0] exp_dack;
        int                exp_ch;
        priorityType = 1'b1;
        DREQ         = 4'b1111;
        tick(); tick(); tick();
        for (int k = 0; k < 5; k++) begin
            exp_ch           = (top_model + k) % NUM_CH;
            exp_dack         = '0;
            exp_dack[exp_ch] = 1'b1;
            checks++;
            if ({DACK, activeChannel, channelValid} !== {exp_dack, chIdx_t'(exp_ch), 1'b1}) begin
                errors++;
                $display("FAIL rotate_grant%0d: got dack=%b ch=%0d want dack=%b ch=%0d",
                         k, DACK, activeChannel, exp_dack, exp_ch);
            end
            if (k < 4) begin
                serviceDone = 1'b1;
                tick();
                serviceDone = 1'b0;
                checks++;
                if ({HRQ, DACK} !== 5'b0) begin
                    errors++; $display("FAIL rotate_gap%0d: got %b want 00000", k, {HRQ, DACK});
                end
                tick();
                checks++;
                if ({HRQ, DACK} !== 5'b10000) begin
                    errors++; $display("FAIL rotate_hold%0d: got %b want 10000", k, {HRQ, DACK});
                end
                tick();
            end
        end
        release_service();
        top_model = (top_model + 5) % NUM_CH;
    endtask

    task automatic test_mask_swreq();
        priorityType = 1'b0;
        top_model    = 0;
        maskReg      = 4'b0001;
        DREQ         = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++; $display("FAIL masked_no_hrq%0d: HRQ got %b want 0", i, HRQ);
            end
        end
        swReqReg = 4'b0001;
        tick();
        tick();
        checks++;
        if ({HRQ, DACK} !== 5'b10000) begin
            errors++; $display("FAIL swreq_hrq: got %b want 10000", {HRQ, DACK});
        end
        tick();
        checks++;
        if (DACK !== 4'b0001) begin
            errors++; $display("FAIL swreq_dack: got %b want 0001", DACK);
        end
        release_service();
        maskReg = '0;
    endtask

    task automatic test_sense_disable();
        dreqSenseLow = 1'b1;
        DREQ         = 4'b1011;
        tick(); tick(); tick();
        checks++;
        if ({DACK, activeChannel} !== {4'b0100, chIdx_t'(2)}) begin
            errors++;
            $display("FAIL sense_low: got dack=%b ch=%0d want dack=0100 ch=2", DACK, activeChannel);
        end
        release_service();
        controllerDisable = 1'b1;
        DREQ              = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (HRQ !== 1'b0) begin
                errors++; $display("FAIL disabled%0d: HRQ got %b want 0", i, HRQ);
            end
        end
        controllerDisable = 1'b0;
        dreqSenseLow      = 1'b0;
        tick(); tick();
    endtask

    task automatic test_hold_no_hlda();
        logic exp_hrq [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        HLDA = 1'b0;
        DREQ = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) DREQ = 4'b0000;
            tick();
            checks++;
            if ({HRQ, DACK} !== {exp_hrq[i], 4'b0000}) begin
                errors++;
                $display("FAIL no_hlda%0d: got %b want %b", i, {HRQ, DACK}, {exp_hrq[i], 4'b0000});
            end
        end
    endtask

    task automatic test_hlda_drop();
        priorityType = 1'b1;
        HLDA         = 1'b1;
        DREQ         = 4'b0100;
        tick(); tick(); tick();
        checks++;
        if (DACK !== 4'b0100) begin
            errors++; $display("FAIL drop_grant: got %b want 0100", DACK);
        end
        HLDA = 1'b0;
        tick();
        checks++;
        if ({HRQ, DACK, channelValid} !== 6'b0) begin
            errors++; $display("FAIL drop_abort: got %b want 000000", {HRQ, DACK, channelValid});
        end
        DREQ = 4'b0000;
        tick(); tick();
        DREQ = 4'b1111;
        tick(); tick();
        HLDA = 1'b1;
        tick();
        checks++;
        if (DACK !== 4'b0001) begin
            errors++; $display("FAIL drop_toppri: got %b want 0001", DACK);
        end
        release_service();
        top_model = 1;
    endtask

    task automatic test_reset_mid_service();
        DREQ = 4'b0100;
        tick(); tick(); tick();
        checks++;
        if (DACK !== 4'b0100) begin
            errors++; $display("FAIL rst_pre_grant: got %b want 0100", DACK);
        end
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({HRQ, DACK, activeChannel, channelValid, serviceStart} !== '0) begin
                errors++;
                $display("FAIL rst_mid%0d: got %b want all zero", i,
                         {HRQ, DACK, activeChannel, channelValid, serviceStart});
            end
        end
        RESET = 1'b0;
        DREQ  = 4'b1111;
        tick(); tick(); tick();
        checks++;
        if (DACK !== 4'b0001) begin
            errors++; $display("FAIL rst_toppri: got %b want 0001", DACK);
        end
        release_service();
        top_model = 1;
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] eff, exp_dack;
        int                w, extra;
        for (int it = 0; it < 40; it++) begin
            priorityType      = 1'($urandom);
            dreqSenseLow      = 1'($urandom);
            maskReg           = 4'($urandom);
            swReqReg          = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            controllerDisable = ($urandom_range(0, 7) == 0);
            DREQ              = 4'($urandom);
            eff = model_eff(DREQ, dreqSenseLow, controllerDisable, maskReg, swReqReg);
            if (!priorityType) top_model = 0;
            if (eff == '0) begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    checks++;
                    if (HRQ !== 1'b0) begin
                        errors++; $display("FAIL rnd%0d_noreq: HRQ got %b want 0", it, HRQ);
                    end
                end
                DREQ     = {NUM_CH{dreqSenseLow}};
                swReqReg = '0;
                tick();
            end else begin
                w           = model_winner(eff, top_model);
                exp_dack    = '0;
                exp_dack[w] = 1'b1;
                tick();
                tick();
                checks++;
                if ({HRQ, DACK} !== 5'b10000) begin
                    errors++; $display("FAIL rnd%0d_hold: got %b want 10000", it, {HRQ, DACK});
                end
                tick();
                checks++;
                if ({HRQ, DACK, activeChannel, channelValid, serviceStart}
                    !== {1'b1, exp_dack, chIdx_t'(w), 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL rnd%0d_grant: got dack=%b ch=%0d want dack=%b ch=%0d eff=%b",
                             it, DACK, activeChannel, exp_dack, w, eff);
                end
                extra = $urandom_range(0, 2);
                for (int i = 0; i < extra; i++) begin
                    DREQ = 4'($urandom);
                    tick();
                    checks++;
                    if ({DACK, activeChannel, serviceStart} !== {exp_dack, chIdx_t'(w), 1'b0}) begin
                        errors++;
                        $display("FAIL rnd%0d_stable: got dack=%b ch=%0d start=%b want %b %0d 0",
                                 it, DACK, activeChannel, serviceStart, exp_dack, w);
                    end
                end
                serviceDone = 1'b1;
                DREQ        = {NUM_CH{dreqSenseLow}};
                swReqReg    = '0;
                tick();
                serviceDone = 1'b0;
                checks++;
                if ({HRQ, DACK, channelValid} !== 6'b0) begin
                    errors++;
                    $display("FAIL rnd%0d_done: got %b want 000000", it, {HRQ, DACK, channelValid});
                end
                if (priorityType) top_model = (w + 1) % NUM_CH;
                tick();
            end
        end
    endtask

    initial begin
        RESET             = 1'b1;
        DREQ              = '0;
        HLDA              = 1'b0;
        priorityType      = 1'b0;
        dreqSenseLow      = 1'b0;
        controllerDisable = 1'b0;
        maskReg           = '0;
        swReqReg          = '0;
        serviceDone       = 1'b0;
        test_reset();
        test_fixed_latency();
        test_rotating();
        test_mask_swreq();
        test_sense_disable();
        test_hold_no_hlda();
        test_hlda_drop();
        test_reset_mid_service();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
